// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding, default bus
// widths and the register map of the UART peripheral it usually talks to.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  // UART register slave offsets
  localparam logic [31:0] UART_TX_DATA      = 32'h00;
  localparam logic [31:0] UART_RX_DATA      = 32'h04;
  localparam logic [31:0] UART_BAUD         = 32'h08;
  localparam logic [31:0] UART_STATUS       = 32'h0C;
  localparam logic [31:0] UART_CONTROL      = 32'h10;
  localparam logic [31:0] UART_STATUS_CLEAR = 32'h14;
  localparam logic [31:0] UART_INTERRUPT_EN = 32'h18;

endpackage

// File: rtl/apb_requester.sv
// Single-outstanding APB initiator: one command in, one SETUP/ACCESS transfer
// on the bus, one response out, with a bounded wait-state timeout.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetn,
  // Handshakes: a beat transfers in a cycle where valid & ready are both high;
  // a producer holds valid and its payload stable until that cycle.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output apb_state_e          dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [STRB_W-1:0]   pstrb_d;
  logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_d;

  assign cmd_ready = (state_q == IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    paddr_d       = PADDR;
    psel_d        = PSELx;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = SETUP;
          wait_cnt_d = '0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          // Reads never expose stale write data or strobes on the bus
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          pstrb_d    = cmd_write ? cmd_strb : '0;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // Abort once the count of low-PREADY ACCESS cycles hits the limit
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_d == TIMEOUT_LIM)) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      PADDR       <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      PADDR       <= paddr_d;
      PSELx       <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: cycle-exact APB timing, wait states,
// slave error, timeout, response backpressure and mid-transfer reset.
module tb_apb_requester;
  import apb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA = '0;
  logic              PREADY = 1'b1;
  logic              PSLVERR = 1'b0;
  apb_state_e        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: present a command in cycle 0, return in cycle 1
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                       input logic [DATA_W-1:0] exp_rdata);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_valid = 1'b1;
    check("cmd_ready_c0", cmd_ready, 1);
    exp_q.push_back(exp_rdata);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard: compare the current response against the expected queue
  task automatic check_rsp(input string tag, input logic e_err, input logic e_to);
    logic [DATA_W-1:0] e;
    check({tag, "_valid"}, rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e);
    end
    check({tag, "_err"}, rsp_err, e_err);
    check({tag, "_timeout"}, rsp_timeout, e_to);
  endtask

  // Bounded wait for rsp_valid; an expired budget is a failure
  task automatic wait_rsp(input string tag, input int budget);
    int c;
    c = 0;
    while (!rsp_valid && c < budget) begin
      tick();
      c++;
    end
    if (!rsp_valid) check({tag, "_rsp_wait"}, 0, 1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_state", dbg_state, IDLE);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Write 0x8, zero wait states
    PREADY = 1'b1;
    issue(1'b1, UART_BAUD, 32'h1, 4'b0001, 32'h0);
    check("w8_c1_psel", PSELx, 1);
    check("w8_c1_penable", PENABLE, 0);
    check("w8_c1_paddr", PADDR, 32'h8);
    check("w8_c1_pwrite", PWRITE, 1);
    check("w8_c1_pwdata", PWDATA, 32'h1);
    check("w8_c1_pstrb", PSTRB, 4'b0001);
    check("w8_c1_cmd_ready", cmd_ready, 0);
    tick();
    check("w8_c2_psel", PSELx, 1);
    check("w8_c2_penable", PENABLE, 1);
    check("w8_c2_rsp_valid", rsp_valid, 0);
    tick();
    check_rsp("w8_c3", 0, 0);
    check("w8_c3_psel", PSELx, 0);
    check("w8_c3_penable", PENABLE, 0);
    tick();
    check("w8_c4_cmd_ready", cmd_ready, 1);
    check("w8_c4_rsp_valid", rsp_valid, 0);

    // Read 0xC with three wait states
    PREADY = 1'b0;
    PRDATA = 32'hBAD0_BAD0;
    issue(1'b0, UART_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0000_000A);
    check("rC_c1_pstrb", PSTRB, 0);
    check("rC_c1_pwdata", PWDATA, 0);
    check("rC_c1_pwrite", PWRITE, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        PREADY = 1'b1;
        PRDATA = 32'h0000_000A;
      end
      check($sformatf("rC_c%0d_penable", c), PENABLE, 1);
      check($sformatf("rC_c%0d_paddr", c), PADDR, 32'hC);
      check($sformatf("rC_c%0d_pstrb", c), PSTRB, 0);
      check($sformatf("rC_c%0d_rsp_valid", c), rsp_valid, 0);
    end
    tick();
    check_rsp("rC_c6", 0, 0);
    check("rC_c6_psel", PSELx, 0);
    PRDATA = 32'h0;
    tick();

    // Write 0x0 with slave error
    issue(1'b1, UART_TX_DATA, 32'hDEAD_BEEF, 4'hF, 32'h0);
    PSLVERR = 1'b1;
    check("w0_c1_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("w0_c1_pstrb", PSTRB, 4'hF);
    tick();
    tick();
    check_rsp("w0_c3", 1, 0);
    PSLVERR = 1'b0;
    tick();

    // Hung slave: timeout after 16 ACCESS cycles
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    issue(1'b0, UART_RX_DATA, 32'h0, 4'h0, 32'h0);
    for (int c = 2; c <= 17; c++) tick();
    check("to_c17_psel", PSELx, 1);
    check("to_c17_penable", PENABLE, 1);
    check("to_c17_rsp_valid", rsp_valid, 0);
    tick();
    check_rsp("to_c18", 1, 1);
    check("to_c18_psel", PSELx, 0);
    check("to_c18_penable", PENABLE, 0);
    PREADY = 1'b1;
    PRDATA = 32'h0;
    tick();
    issue(1'b1, UART_CONTROL, 32'h3, 4'h1, 32'h0);
    wait_rsp("after_to", 10);
    check_rsp("after_to", 0, 0);
    tick();

    // Response backpressure with a second command waiting
    rsp_ready = 1'b0;
    issue(1'b1, UART_INTERRUPT_EN, 32'h5, 4'h1, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = UART_BAUD;
    exp_q.push_back(32'h0000_00C3);
    check("bp_c1_paddr", PADDR, 32'h18);
    tick();
    check("bp_c2_paddr", PADDR, 32'h18);
    check("bp_c2_pwrite", PWRITE, 1);
    for (int c = 3; c <= 7; c++) begin
      tick();
      check($sformatf("bp_c%0d_rsp_valid", c), rsp_valid, 1);
      check($sformatf("bp_c%0d_rdata", c), rsp_rdata, 0);
      check($sformatf("bp_c%0d_err", c), rsp_err, 0);
      check($sformatf("bp_c%0d_cmd_ready", c), cmd_ready, 0);
      check($sformatf("bp_c%0d_psel", c), PSELx, 0);
    end
    tick();
    rsp_ready = 1'b1;
    check_rsp("bp_c8", 0, 0);
    tick();
    check("bp_c9_cmd_ready", cmd_ready, 1);
    PRDATA = 32'h0000_00C3;
    tick();
    cmd_valid = 1'b0;
    check("bp_c10_psel", PSELx, 1);
    check("bp_c10_paddr", PADDR, 32'h8);
    check("bp_c10_pwrite", PWRITE, 0);
    tick();
    tick();
    check_rsp("bp2", 0, 0);
    PRDATA = 32'h0;
    tick();

    // Reset during ACCESS
    PREADY = 1'b0;
    issue(1'b1, UART_STATUS_CLEAR, 32'hFF, 4'hF, 32'h0);
    void'(exp_q.pop_back());
    tick();
    check("rstm_c2_penable", PENABLE, 1);
    #2 resetn = 1'b0;
    #1;
    check("rstm_psel", PSELx, 0);
    check("rstm_penable", PENABLE, 0);
    check("rstm_paddr", PADDR, 0);
    check("rstm_pwdata", PWDATA, 0);
    check("rstm_pstrb", PSTRB, 0);
    check("rstm_pwrite", PWRITE, 0);
    check("rstm_rsp_valid", rsp_valid, 0);
    check("rstm_state", dbg_state, IDLE);
    tick();
    tick();
    resetn = 1'b1;
    PREADY = 1'b1;
    check("rstm_after_rsp_valid", rsp_valid, 0);
    PRDATA = 32'h0000_0055;
    issue(1'b0, UART_BAUD, 32'h0, 4'h0, 32'h0000_0055);
    check("rstm_rd_paddr", PADDR, 32'h8);
    tick();
    tick();
    check_rsp("rstm_rd", 0, 0);
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB initiator that turns single-beat command requests into APB setup/access transfers. It drives the PSELx/PENABLE/PWRITE/PADDR/PWDATA/PSTRB bus into a peripheral register block such as the UART register slave, with the UART baud register at 0x8 and status at 0xC. It handles PREADY wait states, captures PRDATA/PSLVERR and returns one response per command. A bounded wait-state timeout guarantees forward progress against a hung slave.

Parameters:
ADDR_W, 32, PADDR and cmd_addr width
DATA_W, 32, PWDATA/PRDATA width; PSTRB width is DATA_W/8
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, also used as PCLK
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_W  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB write strobes
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset, asynchronous on resetn low: state IDLE. PSELx, PENABLE, PWRITE, PADDR, PWDATA and PSTRB all 0. rsp_valid, rsp_rdata, rsp_err and rsp_timeout all 0. Wait counter 0.
- Reset mid-transfer: the transfer is dropped, the bus returns to idle immediately, and no response is issued.
- All APB and response outputs are registered. cmd_ready = (state == IDLE).
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: on cmd_valid, latch the command into the P* outputs and set PSELx=1, PENABLE=0.
  - Reads force PSTRB=0 and PWDATA=0.
  - cmd_addr passes through unmodified; no alignment check.
- SETUP: exactly one cycle. PREADY, PSLVERR and PRDATA are ignored. Set PENABLE=1 and go to ACCESS.
- ACCESS: PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY=1: transfer completes. rsp_rdata = PRDATA on reads, 0 on writes. rsp_err = PSLVERR, rsp_timeout=0.
  - On completion: PSELx=0, PENABLE=0, rsp_valid=1, go to RESP.
  - PREADY=0: the wait counter increments.
  - Timeout: when the counter reaches TIMEOUT_CYCLES (nonzero) with PREADY still low, abort. Deassert PSELx and PENABLE, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - The wait counter clears on entry to SETUP.
- RESP: rsp_* is held stable until rsp_ready. In the rsp_valid & rsp_ready cycle, clear rsp_valid and go to IDLE.
- Latency, zero wait states: command accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - With rsp_ready held high, the next command is accepted at cycle 4.
  - Each wait state adds one cycle.
- At most one outstanding transfer. cmd_* is ignored outside IDLE.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle where PREADY=1.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, RESP}
  - localparams for default ADDR_W and DATA_W
  - shared UART register offsets: tx_data 0x0, rx_data 0x4, baud 0x8, status 0xC, control 0x10, status_clear 0x14, interrupt_en 0x18
- No sub-module. The FSM, output registers and wait counter live in one module.

Test Plan:
- Write to 0x8, wdata 0x1, strb 4'b0001, PREADY tied 1 -> PSELx high at cycles 1-2, PENABLE high at cycle 2 only, PADDR=0x8, rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read from 0xC, slave drives PRDATA=0x0000000A with PREADY low for 3 cycles -> ACCESS lasts 4 cycles with PADDR stable, rsp_rdata=0xA, rsp_valid at cycle 6, PSTRB=0.
- Write to 0x0, wdata 0xDEADBEEF, PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
- PREADY held low, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, PSELx/PENABLE=0, rsp_err=1, rsp_timeout=1; the next command proceeds normally.
- rsp_ready low for 5 cycles and cmd_valid held with a second command -> response held stable, cmd_ready=0, second command accepted in the cycle after the handshake.
- resetn asserted during ACCESS -> all outputs 0 asynchronously, no rsp_valid; after release, a read of 0x8 completes normally.
